div_issue_cache: RTL and testbench

Upstream front-end for the iterative divider. It accepts divide/remainder requests from the EXU and serves repeated identical requests from a small result cache. Misses go to the divider over its stage_if pair, and the returned result is registered, cached and forwarded. This hides the divider's ~36-cycle latency for recurring operand pairs, such as a DIV/REM loop over constant operands.

---
 rtl/exu_types_pkg.sv | 26 ++
 rtl/div_issue_cache_if.sv | 22 ++
 rtl/div_issue_cache_lookup.sv | 28 ++
 rtl/div_issue_cache.sv | 147 ++++++++++++++
 tb/tb_div_issue_cache.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exu_types_pkg.sv
// Shared EXU divider types: operation encoding, request payload and result-cache entry.
package exu_types_pkg;

  typedef enum logic [2:0] {
    DIV_NONE = 3'd0,
    DIV_DIV  = 3'd1,
    DIV_DIVU = 3'd2,
    DIV_REM  = 3'd3,
    DIV_REMU = 3'd4
  } riscv_div_op_e;

  typedef struct packed {
    riscv_div_op_e op;
    logic [31:0]   data_a;
    logic [31:0]   data_b;
  } div_req_t;

  typedef struct packed {
    logic          valid;
    riscv_div_op_e op;
    logic [31:0]   a;
    logic [31:0]   b;
    logic [31:0]   result;
  } div_cache_entry_t;

endpackage

// File: rtl/div_issue_cache_if.sv
// Generic valid/ready stage handshake carrying a typed payload.
interface stage_if #(
  parameter type payload_t = logic [31:0]
) ();

  logic     valid;
  logic     ready;
  payload_t payload;

  modport master (
    output valid,
    output payload,
    input  ready
  );

  modport slave (
    input  valid,
    input  payload,
    output ready
  );

endinterface

// File: rtl/div_issue_cache_lookup.sv
// Fully-associative match over the result cache; fills never duplicate a key, so
// at most one entry can match and the OR-reduce of results is safe.
module div_cache_lookup
  import exu_types_pkg::*;
#(
  parameter int unsigned ENTRIES = 2
) (
  input  div_cache_entry_t [ENTRIES-1:0] entries_i,
  input  riscv_div_op_e                  op_i,
  input  logic [31:0]                    a_i,
  input  logic [31:0]                    b_i,
  output logic                           hit_o,
  output logic [31:0]                    hit_data_o
);

  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (entries_i[i].valid && (entries_i[i].op == op_i) &&
          (entries_i[i].a == a_i) && (entries_i[i].b == b_i)) begin
        hit_o      = 1'b1;
        hit_data_o = hit_data_o | entries_i[i].result;
      end
    end
  end

endmodule

// File: rtl/div_issue_cache.sv
// Divider front-end with a small result cache for repeated DIV/REM operand pairs.
// Define DIV_ISSUE_SPECIAL_EN to resolve divide-by-zero and signed overflow locally.
module div_issue_cache
  import exu_types_pkg::*;
#(
  parameter int unsigned ENTRIES = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  stage_if.slave  req_in,
  stage_if.master res_out,
  stage_if.master div_req,
  stage_if.slave  div_rsp
);

  localparam int unsigned VpW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                         state_q, state_d;
  div_req_t                       req_q;
  div_req_t                       in_req;
  logic [31:0]                    result_q;
  logic [31:0]                    rsp_data;
  logic [31:0]                    idle_result;
  div_cache_entry_t [ENTRIES-1:0] entries_q;
  logic [VpW-1:0]                 vp_q;
  logic                           hit;
  logic [31:0]                    hit_data;
  logic                           special;
  logic [31:0]                    special_data;
  logic                           resolve_now;
  logic                           idle_fire;
  logic                           rsp_fire;

  assign in_req    = req_in.payload;
  assign rsp_data  = div_rsp.payload;
  assign idle_fire = (state_q == S_IDLE) && req_in.valid;
  assign rsp_fire  = (state_q == S_WAIT) && div_rsp.valid;

  div_cache_lookup #(
    .ENTRIES(ENTRIES)
  ) u_lookup (
    .entries_i (entries_q),
    .op_i      (in_req.op),
    .a_i       (in_req.data_a),
    .b_i       (in_req.data_b),
    .hit_o     (hit),
    .hit_data_o(hit_data)
  );

`ifdef DIV_ISSUE_SPECIAL_EN
  always_comb begin
    special      = 1'b0;
    special_data = '0;
    if (in_req.data_b == '0) begin
      special      = 1'b1;
      special_data = ((in_req.op == DIV_DIV) || (in_req.op == DIV_DIVU)) ? 32'hFFFF_FFFF
                                                                         : in_req.data_a;
    end else if (((in_req.op == DIV_DIV) || (in_req.op == DIV_REM)) &&
                 (in_req.data_a == 32'h8000_0000) && (in_req.data_b == 32'hFFFF_FFFF)) begin
      special      = 1'b1;
      special_data = (in_req.op == DIV_DIV) ? 32'h8000_0000 : 32'h0;
    end
  end
`else
  assign special      = 1'b0;
  assign special_data = '0;
`endif

  // Classification priority: no-op, local special case, cache hit, else divider.
  always_comb begin
    resolve_now = 1'b1;
    idle_result = '0;
    if (in_req.op == DIV_NONE) begin
      idle_result = '0;
    end else if (special) begin
      idle_result = special_data;
    end else if (hit) begin
      idle_result = hit_data;
    end else begin
      resolve_now = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_in.valid)   state_d = resolve_now ? S_RESP : S_ISSUE;
      S_ISSUE: if (div_req.ready)  state_d = S_WAIT;
      S_WAIT:  if (div_rsp.valid)  state_d = S_RESP;
      S_RESP:  if (res_out.ready)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_in.ready  = 1'b0;
    div_req.valid = 1'b0;
    div_rsp.ready = 1'b0;
    res_out.valid = 1'b0;
    unique case (state_q)
      S_IDLE:  req_in.ready  = 1'b1;
      S_ISSUE: div_req.valid = 1'b1;
      S_WAIT:  div_rsp.ready = 1'b1;
      S_RESP:  res_out.valid = 1'b1;
      default: ;
    endcase
  end

  assign div_req.payload = req_q;
  assign res_out.payload = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      result_q  <= '0;
      entries_q <= '0;
      vp_q      <= '0;
    end else begin
      if (idle_fire) begin
        req_q    <= in_req;
        result_q <= idle_result;
      end
      // Only divider results allocate; round-robin victim keeps keys unique.
      if (rsp_fire) begin
        result_q <= rsp_data;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
          if (vp_q == VpW'(i)) begin
            entries_q[i] <= '{valid: 1'b1, op: req_q.op, a: req_q.data_a, b: req_q.data_b,
                              result: rsp_data};
          end
        end
        vp_q <= (vp_q == VpW'(ENTRIES - 1)) ? '0 : vp_q + VpW'(1);
      end
    end
  end

endmodule

// File: tb/tb_div_issue_cache.sv
// Randomised bench for div_issue_cache with a stub divider and a FIFO-replacement cache model.
module tb_div_issue_cache;
  import exu_types_pkg::*;

  localparam int unsigned ENTRIES = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  stage_if #(.payload_t(div_req_t))    req_if ();
  stage_if #(.payload_t(logic [31:0])) res_if ();
  stage_if #(.payload_t(div_req_t))    dreq_if ();
  stage_if #(.payload_t(logic [31:0])) drsp_if ();

  div_issue_cache #(
    .ENTRIES(ENTRIES)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_in (req_if),
    .res_out(res_if),
    .div_req(dreq_if),
    .div_rsp(drsp_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int div_cnt  = 0;
  int res_cnt  = 0;
  int stub_lat = 2;
  int stub_stall = 0;
  bit stub_bad = 1'b0;
  div_req_t mq[$];

  function automatic logic [31:0] ref_div(riscv_div_op_e op, logic [31:0] a, logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      DIV_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      DIV_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      DIV_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      DIV_REMU: begin
        if (b == 0) return a;
        return a % b;
      end
      default: return 32'h0;
    endcase
  endfunction

  // Returns whether the request should reach the divider; updates the FIFO cache model.
  function automatic bit model_needs_div(riscv_div_op_e op, logic [31:0] a, logic [31:0] b);
    div_req_t k;
    k = '{op: op, data_a: a, data_b: b};
    if (op == DIV_NONE) return 1'b0;
`ifdef DIV_ISSUE_SPECIAL_EN
    if (b == 0) return 1'b0;
    if ((op == DIV_DIV || op == DIV_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1'b0;
`endif
    foreach (mq[i]) if (mq[i] == k) return 1'b0;
    mq.push_back(k);
    if (mq.size() > ENTRIES) void'(mq.pop_front());
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (dreq_if.valid === 1'b1 && dreq_if.ready === 1'b1) div_cnt <= div_cnt + 1;
    if (res_if.valid === 1'b1 && res_if.ready === 1'b1) res_cnt <= res_cnt + 1;
  end

  // Stub divider: optional ready stall, then a response after stub_lat cycles.
  initial begin : stub
    div_req_t sp;
    dreq_if.ready   = 1'b0;
    drsp_if.valid   = 1'b0;
    drsp_if.payload = '0;
    forever begin
      @(negedge clk);
      if (dreq_if.valid === 1'b1) begin
        sp = dreq_if.payload;
        for (int i = 0; i < stub_stall; i++) begin
          @(negedge clk);
          if (dreq_if.valid !== 1'b1 || dreq_if.payload !== sp) stub_bad = 1'b1;
        end
        dreq_if.ready = 1'b1;
        @(negedge clk);
        dreq_if.ready = 1'b0;
        for (int i = 0; i < stub_lat; i++) @(negedge clk);
        drsp_if.valid   = 1'b1;
        drsp_if.payload = ref_div(sp.op, sp.data_a, sp.data_b);
        @(negedge clk);
        drsp_if.valid = 1'b0;
      end
    end
  end

  // One request from idle to delivered result; starts and ends on a falling edge.
  task automatic do_req(input riscv_div_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] res_v, output int lat,
                        output int ndiv, output int nres, output bit bad);
    int d0, r0;
    d0 = div_cnt; r0 = res_cnt; bad = 1'b0; lat = -1; res_v = 'x;
    if (req_if.ready !== 1'b1) bad = 1'b1;
    req_if.valid   = 1'b1;
    req_if.payload = '{op: op, data_a: a, data_b: b};
    @(negedge clk);
    req_if.valid = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (req_if.ready !== 1'b0) bad = 1'b1;
      if (res_if.valid === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    if (lat > 0) begin
      res_v = res_if.payload;
      if (hold > 0) begin
        res_if.ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
          @(negedge clk);
          if (res_if.valid !== 1'b1 || res_if.payload !== res_v || req_if.ready !== 1'b0)
            bad = 1'b1;
        end
        res_if.ready = 1'b1;
      end
      @(negedge clk);
      if (res_if.valid !== 1'b0) bad = 1'b1;
    end
    ndiv = div_cnt - d0;
    nres = res_cnt - r0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 6;
    if (req_if.ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_if.ready); end
    if (dreq_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_div_valid: got %b want 0", dreq_if.valid); end
    if (dreq_if.payload !== '0) begin n_fail++; $display("FAIL reset_div_payload: got %h want 0", dreq_if.payload); end
    if (drsp_if.ready !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_ready: got %b want 0", drsp_if.ready); end
    if (res_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_if.valid); end
    if (res_if.payload !== 32'h0) begin n_fail++; $display("FAIL reset_res_payload: got %h want 0", res_if.payload); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_if.ready !== 1'b1 || res_if.valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: ready=%b valid=%b want 1/0", req_if.ready, res_if.valid);
    end
  endtask

  task automatic run_table(input string name, input riscv_div_op_e ops[], input logic [31:0] as[],
                           input logic [31:0] bs[]);
    logic [31:0] r;
    int lat, nd, nr;
    bit bad, exp_div;
    for (int i = 0; i < ops.size(); i++) begin
      exp_div = model_needs_div(ops[i], as[i], bs[i]);
      do_req(ops[i], as[i], bs[i], 0, r, lat, nd, nr, bad);
      n_checks += 3;
      if (r !== ref_div(ops[i], as[i], bs[i])) begin
        n_fail++; $display("FAIL %s_result[%0d]: got %h want %h", name, i, r, ref_div(ops[i], as[i], bs[i]));
      end
      if (nd != int'(exp_div)) begin
        n_fail++; $display("FAIL %s_divider_traffic[%0d]: got %0d want %0d", name, i, nd, exp_div);
      end
      if ((exp_div ? lat <= 1 : lat != 1) || nr != 1 || bad) begin
        n_fail++; $display("FAIL %s_timing[%0d]: lat=%0d nres=%0d bad=%0b want miss=%0b nres=1", name, i, lat, nr, bad, exp_div);
      end
    end
  endtask

  task automatic test_miss_hit();
    riscv_div_op_e ops[] = '{DIV_DIVU, DIV_DIVU};
    logic [31:0] as[] = '{32'd100, 32'd100};
    logic [31:0] bs[] = '{32'd7, 32'd7};
    stub_lat = 20; stub_stall = 0;
    run_table("miss_hit", ops, as, bs);
  endtask

  task automatic test_replacement();
    riscv_div_op_e ops[] = '{DIV_REMU, DIV_REMU, DIV_REMU, DIV_REMU, DIV_REMU};
    logic [31:0] as[] = '{32'd10, 32'd11, 32'd12, 32'd10, 32'd12};
    logic [31:0] bs[] = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd3};
    stub_lat = 3;
    run_table("replace", ops, as, bs);
  endtask

  task automatic test_special();
    riscv_div_op_e ops[] = '{DIV_DIV, DIV_DIV, DIV_REM, DIV_REMU, DIV_DIV, DIV_REM};
    logic [31:0] as[] = '{32'd5, 32'h8000_0000, 32'd7, 32'd9, 32'd5, 32'h8000_0000};
    logic [31:0] bs[] = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
    stub_lat = 2;
    run_table("special", ops, as, bs);
  endtask

  task automatic test_div_none();
    riscv_div_op_e ops[] = '{DIV_NONE, DIV_NONE};
    logic [31:0] as[] = '{$urandom(), 32'd42};
    logic [31:0] bs[] = '{$urandom(), 32'd0};
    run_table("div_none", ops, as, bs);
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    int lat, nd, nr;
    bit bad, exp_div;
    stub_stall = 5; stub_lat = 4;
    exp_div = model_needs_div(DIV_DIVU, 32'd1000, 32'd9);
    do_req(DIV_DIVU, 32'd1000, 32'd9, 10, r, lat, nd, nr, bad);
    n_checks += 4;
    if (r !== 32'd111) begin n_fail++; $display("FAIL bp_result: got %h want %h", r, 32'd111); end
    if (nd != int'(exp_div)) begin n_fail++; $display("FAIL bp_divider_traffic: got %0d want %0d", nd, exp_div); end
    if (bad || nr != 1 || lat <= 6) begin
      n_fail++; $display("FAIL bp_handshake: bad=%0b nres=%0d lat=%0d want 0/1/>6", bad, nr, lat);
    end
    if (stub_bad) begin n_fail++; $display("FAIL bp_div_payload_stable: got unstable want stable"); end
    stub_stall = 0;
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    int lat, nd, nr, r0, d0;
    bit bad, exp_div, fired;
    stub_lat = 20;
    void'(model_needs_div(DIV_DIVU, 32'd500, 32'd5));
    d0 = div_cnt;
    req_if.valid   = 1'b1;
    req_if.payload = '{op: DIV_DIVU, data_a: 32'd500, data_b: 32'd5};
    @(negedge clk);
    req_if.valid = 1'b0;
    fired = 1'b0;
    for (int k = 0; k < 20 && !fired; k++) begin
      @(negedge clk);
      fired = (div_cnt != d0);
    end
    n_checks++;
    if (!fired) begin n_fail++; $display("FAIL arst_issue: got no divider request want one"); end
    r0 = res_cnt;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (req_if.ready !== 1'b1 || dreq_if.valid !== 1'b0 || drsp_if.ready !== 1'b0) begin
      n_fail++; $display("FAIL arst_handshake: rdy=%b dv=%b rr=%b want 1/0/0", req_if.ready, dreq_if.valid, drsp_if.ready);
    end
    if (res_if.valid !== 1'b0 || res_if.payload !== 32'h0) begin
      n_fail++; $display("FAIL arst_result: valid=%b payload=%h want 0/0", res_if.valid, res_if.payload);
    end
    if (dreq_if.payload !== '0) begin n_fail++; $display("FAIL arst_div_payload: got %h want 0", dreq_if.payload); end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    repeat (30) @(negedge clk);
    n_checks++;
    if (res_cnt != r0) begin n_fail++; $display("FAIL arst_dropped: got %0d results want 0", res_cnt - r0); end
    stub_lat = 2;
    exp_div = model_needs_div(DIV_DIVU, 32'd500, 32'd5);
    do_req(DIV_DIVU, 32'd500, 32'd5, 0, r, lat, nd, nr, bad);
    n_checks += 2;
    if (r !== 32'd100) begin n_fail++; $display("FAIL arst_retry_result: got %h want %h", r, 32'd100); end
    if (nd != int'(exp_div) || nr != 1 || bad) begin
      n_fail++; $display("FAIL arst_retry_miss: ndiv=%0d nres=%0d bad=%0b want %0d/1/0", nd, nr, bad, exp_div);
    end
  endtask

  task automatic test_random();
    logic [31:0] a_pool[3];
    logic [31:0] b_pool[3];
    riscv_div_op_e op;
    logic [31:0] a, b, r;
    int lat, nd, nr, hold;
    bit bad, exp_div;
    a_pool[0] = 32'd100; a_pool[1] = 32'h8000_0000; a_pool[2] = 32'hFFFF_FFF9;
    b_pool[0] = 32'd0;   b_pool[1] = 32'hFFFF_FFFF; b_pool[2] = 32'd7;
    op = DIV_DIV; a = a_pool[0]; b = b_pool[2];
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        op = riscv_div_op_e'($urandom_range(0, 4));
        a  = a_pool[$urandom_range(0, 2)];
        b  = b_pool[$urandom_range(0, 2)];
      end
      stub_lat   = $urandom_range(0, 6);
      stub_stall = $urandom_range(0, 2);
      hold       = $urandom_range(0, 3);
      exp_div = model_needs_div(op, a, b);
      do_req(op, a, b, hold, r, lat, nd, nr, bad);
      n_checks += 3;
      if (r !== ref_div(op, a, b)) begin
        n_fail++; $display("FAIL rand_result[%0d]: op=%0d a=%h b=%h got %h want %h", i, op, a, b, r, ref_div(op, a, b));
      end
      if (nd != int'(exp_div)) begin
        n_fail++; $display("FAIL rand_divider_traffic[%0d]: got %0d want %0d", i, nd, exp_div);
      end
      if ((exp_div ? lat <= 1 : lat != 1) || nr != 1 || bad) begin
        n_fail++; $display("FAIL rand_timing[%0d]: lat=%0d nres=%0d bad=%0b want miss=%0b", i, lat, nr, bad, exp_div);
      end
    end
    stub_stall = 0;
    n_checks++;
    if (stub_bad) begin n_fail++; $display("FAIL rand_div_payload_stable: got unstable want stable"); end
  endtask

  initial begin
    req_if.valid   = 1'b0;
    req_if.payload = '0;
    res_if.ready   = 1'b1;
    test_reset();
    test_miss_hit();
    test_replacement();
    test_special();
    test_div_none();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
